// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: streams a raster image through two line buffers and a 3x3
// window, drives the window to an external combinational sobel core and
// returns the registered core result on a valid/ready stream.
// Optional feature macro: SOBEL_BORDER_EN (one output per pixel, border = 0).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready/in_pix/in_sof  pixel input stream (raster order)
//   win0..win8                       3x3 window to core, row-major, win4 centre
//   core_out                         core result, combinational from win*
//   out_valid/out_ready/out_pix      edge-magnitude output stream
//   out_last                         final result of a frame
//   sof_err                          sticky: in_sof accepted mid-frame
module sobel_window_ctrl #(
    parameter int unsigned IMG_W = 512,
    parameter int unsigned IMG_H = 512,
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sof,
    output logic [8:0]       win0,
    output logic [8:0]       win1,
    output logic [8:0]       win2,
    output logic [8:0]       win3,
    output logic [8:0]       win4,
    output logic [8:0]       win5,
    output logic [8:0]       win6,
    output logic [8:0]       win7,
    output logic [8:0]       win8,
    input  logic [7:0]       core_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_pix,
    output logic             out_last,
    output logic             sof_err
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d, state_eff;
    logic [COL_W-1:0]   col_q, col_d, col_eff;
    logic [ROW_W-1:0]   row_q, row_d, row_eff;
    logic               sof_err_q, sof_err_d;
    logic               rdy_q;
    logic [PIX_W-1:0]   win_q [3][3];
    logic [PIX_W-1:0]   win_d [3][3];
    logic               s1_v_q, s1_v_d;
    logic               s1_last_q, s1_last_d;
`ifdef SOBEL_BORDER_EN
    logic               s1_int_q, s1_int_d;
`endif
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [7:0]         out_pix_q, out_pix_d;
    logic [PIX_W-1:0]   lb0_q [IMG_W];
    logic [PIX_W-1:0]   lb1_q [IMG_W];
    logic [PIX_W-1:0]   lb0_rd, lb1_rd;
    logic               adv_c, accept_c, restart_c, interior_c, col_last_c, row_last_c;

    // Global pipeline advance; rdy_q keeps in_ready low through reset.
    assign adv_c    = !out_valid_q || out_ready;
    assign in_ready = rdy_q && adv_c;
    assign accept_c = in_valid && in_ready;

    // A mid-frame SOF restarts the frame at (0,0) for this very pixel.
    assign restart_c  = in_sof && ((col_q != '0) || (row_q != '0));
    assign col_eff    = restart_c ? '0 : col_q;
    assign row_eff    = restart_c ? '0 : row_q;
    assign state_eff  = restart_c ? ST_FILL : state_q;
    assign col_last_c = (col_eff == COL_W'(IMG_W - 1));
    assign row_last_c = (row_eff == ROW_W'(IMG_H - 1));
    // RUN implies row >= 2, so only the column needs checking here.
    assign interior_c = (state_eff == ST_RUN) && (col_eff >= COL_W'(2));

    assign lb0_rd = lb0_q[col_eff];
    assign lb1_rd = lb1_q[col_eff];

    // Next-state for counters, frame FSM, window and both pipeline stages.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        sof_err_d   = sof_err_q;
        win_d       = win_q;
        s1_v_d      = s1_v_q;
        s1_last_d   = s1_last_q;
`ifdef SOBEL_BORDER_EN
        s1_int_d    = s1_int_q;
`endif
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_pix_d   = out_pix_q;

        if (accept_c) begin
            sof_err_d = sof_err_q | restart_c;
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = in_pix;

            state_d = state_eff;
            if (col_last_c) begin
                col_d = '0;
                if (row_last_c) begin
                    row_d   = '0;
                    state_d = ST_FILL;
                end else begin
                    row_d = ROW_W'(row_eff + ROW_W'(1));
                    if (row_eff >= ROW_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end else begin
                col_d = COL_W'(col_eff + COL_W'(1));
                row_d = row_eff;
            end
        end

        if (adv_c) begin
`ifdef SOBEL_BORDER_EN
            s1_v_d    = accept_c;
            s1_int_d  = interior_c;
            out_pix_d = s1_int_q ? core_out : 8'd0;
`else
            s1_v_d    = accept_c && interior_c;
            out_pix_d = core_out;
`endif
            s1_last_d   = accept_c && col_last_c && row_last_c;
            out_valid_d = s1_v_q;
            out_last_d  = s1_last_q;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            col_q       <= '0;
            row_q       <= '0;
            sof_err_q   <= 1'b0;
            rdy_q       <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
`ifdef SOBEL_BORDER_EN
            s1_int_q    <= 1'b0;
`endif
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pix_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sof_err_q   <= sof_err_d;
            rdy_q       <= 1'b1;
            win_q       <= win_d;
            s1_v_q      <= s1_v_d;
            s1_last_q   <= s1_last_d;
`ifdef SOBEL_BORDER_EN
            s1_int_q    <= s1_int_d;
`endif
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_pix_q   <= out_pix_d;
        end
    end

    // Line buffers: LB1 takes the row-1 pixel, LB0 the new pixel.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb1_q[col_eff] <= lb0_rd;
            lb0_q[col_eff] <= in_pix;
        end
    end

    assign win0 = 9'(win_q[0][0]);
    assign win1 = 9'(win_q[0][1]);
    assign win2 = 9'(win_q[0][2]);
    assign win3 = 9'(win_q[1][0]);
    assign win4 = 9'(win_q[1][1]);
    assign win5 = 9'(win_q[1][2]);
    assign win6 = 9'(win_q[2][0]);
    assign win7 = 9'(win_q[2][1]);
    assign win8 = 9'(win_q[2][2]);

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_pix   = out_pix_q;
    assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl on a 4x4 image: models the sobel
// core combinationally and predicts outputs from the stored image per pixel.
module tb_sobel_window_ctrl;

    localparam int W = 4;
    localparam int H = 4;
`ifdef SOBEL_BORDER_EN
    localparam int OPF       = W * H;
    localparam int FIRST_IDX = 0;
`else
    localparam int OPF       = (W - 2) * (H - 2);
    localparam int FIRST_IDX = 2 * W + 2;
`endif

    logic       clk, rst_n, in_valid, in_ready, in_sof, out_valid, out_ready, out_last, sof_err;
    logic [7:0] in_pix, core_out, out_pix;
    logic [8:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pix(in_pix), .in_sof(in_sof),
        .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4),
        .win5(win5), .win6(win6), .win7(win7), .win8(win8),
        .core_out(core_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_pix(out_pix), .out_last(out_last), .sof_err(sof_err)
    );

    int vecs = 0;
    int errs = 0;
    int n_out = 0;
    int n_last = 0;
    int rmode = 0;
    int mr = 0;
    int mc = 0;
    logic [7:0] img [H][W];
    logic [8:0] expq [$];
    bit         prev_stall = 0;
    logic [7:0] prev_pix = '0;

    function automatic int abs_i(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Golden sobel: |Gx| + |Gy|, saturated at 255.
    function automatic logic [7:0] sobel9(input int p0, input int p1, input int p2,
                                          input int p3, input int p4, input int p5,
                                          input int p6, input int p7, input int p8);
        int gx, gy, m;
        gx = (p2 + 2 * p5 + p8) - (p0 + 2 * p3 + p6);
        gy = (p6 + 2 * p7 + p8) - (p0 + 2 * p1 + p2);
        m  = abs_i(gx) + abs_i(gy) + 0 * p4;
        return (m > 255) ? 8'd255 : 8'(m);
    endfunction

    assign core_out = sobel9(int'(win0), int'(win1), int'(win2), int'(win3), int'(win4),
                             int'(win5), int'(win6), int'(win7), int'(win8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    // Reference: raster coordinates, stored image, expected result per accept.
    task automatic model_accept(input logic [7:0] p, input bit sof);
        bit interior, last;
        logic [7:0] v;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = p;
        interior = (mr >= 2) && (mc >= 2);
        last     = (mr == H - 1) && (mc == W - 1);
        chk("win8_newest", win8, 32'(p));
        v = 8'd0;
        if (interior) begin
            v = sobel9(img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                       img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                       img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]);
            chk("win4_centre", win4, 32'(img[mr-1][mc-1]));
            chk("win0_topleft", win0, 32'(img[mr-2][mc-2]));
        end
`ifdef SOBEL_BORDER_EN
        expq.push_back({last, v});
`else
        if (interior) expq.push_back({last, v});
`endif
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic send(input logic [7:0] p, input bit sof);
        bit got;
        got = 0;
        in_valid = 1'b1;
        in_pix   = p;
        in_sof   = sof;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("accept_timeout", 32'(got), 32'd1);
        if (got) model_accept(p, sof);
    endtask

    function automatic logic [7:0] gen_pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'd100;
            1:       return (c < 2) ? 8'd0 : 8'd255;
            2:       return 8'(r * 60 + c * 25);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic send_frame(input int kind, input bit gaps, input int start);
        for (int i = start; i < W * H; i++) begin
            send(gen_pix(kind, i / W, i % W), i == start);
            if (gaps && $urandom_range(0, 3) == 0) tick();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && expq.size() != 0; i++) tick();
        repeat (4) tick();
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    // Output monitor: scoreboard compare, stall stability, ready back-pressure.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_hold", out_valid, 1);
                chk("stall_pix_hold", out_pix, 32'(prev_pix));
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                chk("out_expected", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("out_pix", out_pix, 32'(e[7:0]));
                    chk("out_last", out_last, 32'(e[8]));
                end
                n_out++;
                if (out_last) n_last++;
            end
            prev_stall = out_valid && !out_ready;
            prev_pix   = out_pix;
        end
    end

    initial begin
        int n0, l0;
        rst_n = 1'b0; in_valid = 1'b0; in_pix = '0; in_sof = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_pix", out_pix, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_win4", win4, 0);
        chk("rst_win8", win8, 0);
        rst_n = 1'b1;

        // Constant frame: all outputs zero, latency and last position.
        rmode = 0; n0 = n_out; l0 = n_last;
        for (int i = 0; i < W * H; i++) begin
            send(8'd100, i == 0);
            if (i == FIRST_IDX) begin
                chk("lat_after_accept", out_valid, 0);
                tick();
                chk("lat_next_edge", out_valid, 1);
            end
        end
        drain();
        chk("t1_count", 32'(n_out - n0), 32'(OPF));
        chk("t1_lasts", 32'(n_last - l0), 32'd1);

        // Vertical edge: saturated interior results.
        n0 = n_out; l0 = n_last;
        send_frame(1, 0, 0);
        drain();
        chk("t2_count", 32'(n_out - n0), 32'(OPF));
        chk("t2_lasts", 32'(n_last - l0), 32'd1);

        // Random back-pressure and input gaps over ramp and random frames.
        rmode = 1; n0 = n_out; l0 = n_last;
        send_frame(2, 1, 0);
        send_frame(3, 1, 0);
        drain();
        rmode = 0;
        chk("t3_count", 32'(n_out - n0), 32'(2 * OPF));
        chk("t3_lasts", 32'(n_last - l0), 32'd2);

        // Back-to-back frames with different content.
        n0 = n_out; l0 = n_last;
        send_frame(3, 0, 0);
        send_frame(2, 0, 0);
        drain();
        chk("t4_count", 32'(n_out - n0), 32'(2 * OPF));
        chk("t4_lasts", 32'(n_last - l0), 32'd2);

        // Mid-frame SOF at pixel 6: restart and sticky error.
        chk("sof_err_clear", sof_err, 0);
        n0 = n_out; l0 = n_last;
        for (int i = 0; i < 6; i++) send(gen_pix(3, 0, 0), i == 0);
        chk("sof_err_before", sof_err, 0);
        send_frame(3, 0, 0);
        chk("sof_err_set", sof_err, 1);
        drain();
        chk("sof_err_sticky", sof_err, 1);
`ifdef SOBEL_BORDER_EN
        chk("t5_count", 32'(n_out - n0), 32'(6 + OPF));
`else
        chk("t5_count", 32'(n_out - n0), 32'(OPF));
`endif
        chk("t5_lasts", 32'(n_last - l0), 32'd1);

        // Asynchronous reset mid-frame while a result is held.
        for (int i = 0; i < 12; i++) send(gen_pix(3, 0, 0), i == 0);
        rmode = 2;
        out_ready = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", in_ready, 0);
        chk("async_rst_last", out_last, 0);
        chk("async_rst_sof_err", sof_err, 0);
        expq.delete();
        mr = 0;
        mc = 0;
        rmode = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        n0 = n_out; l0 = n_last;
        send_frame(3, 0, 0);
        drain();
        chk("t6_count", 32'(n_out - n0), 32'(OPF));
        chk("t6_lasts", 32'(n_last - l0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
